apb_gpio_irq: RTL



---
 rtl/apb_gpio_irq.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_gpio_irq.sv
// -----------------------------------------------------------------------------
// apb_gpio_irq
//
// APB GPIO slave. It provides WIDTH pins with an input synchroniser, atomic
// set/clear/toggle of the outputs, and per-pin interrupt detection. Each pin
// can be level or edge type, with selectable polarity.
//
// Register map (PADDR[7:2] decoded, PADDR[1:0] ignored):
//   0x00 IN     ro   synchronised (optionally debounced) input
//   0x04 OUT    rw   pad output values
//   0x08 DIR    rw   pad output enables, 1 = drive
//   0x0C SET    wo   1 sets the OUT bit      (reads 0)
//   0x10 CLR    wo   1 clears the OUT bit    (reads 0)
//   0x14 TGL    wo   1 inverts the OUT bit   (reads 0)
//   0x18 IE     rw   interrupt enable
//   0x1C ITYPE  rw   1 = edge, 0 = level
//   0x20 IPOL   rw   1 = rising/high, 0 = falling/low
//   0x24 ISTAT  rw1c interrupt status
// All writes are byte-masked by PSTRB. Unmapped addresses raise PSLVERR,
// read as 0 and discard writes.
//
// APB handshake: PREADY = PSEL & PENABLE, so there are no wait states.
// A write commits on the PCLK edge where PSEL & PENABLE & PWRITE is high.
// PRDATA is valid whenever PSEL & !PWRITE, and is 0 otherwise.
//
// Parameters:
//   WIDTH        1..32  number of pins; register bits >= WIDTH read 0
//   SYNC_STAGES  2..4   input synchroniser depth
//   DEB_DIV      >= 2   debounce tick divider (debounce build only)
//
// Optional feature macro:
//   GPIO_DEBOUNCE_EN  adds a tick-sampled 3-sample debouncer between the
//                     synchroniser and IN.
//
// Ports:
//   PCLK, PRST_N                    clock and asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PSTRB, PWDATA                   APB request
//   PRDATA, PREADY, PSLVERR         APB response
//   GpioIn                          asynchronous pad inputs
//   GpioOut, GpioOEn                pad output value and output enable
//   GpioIrq                         registered level interrupt
// -----------------------------------------------------------------------------
module apb_gpio_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_DIV     = 16
) (
  input  logic             PCLK,
  input  logic             PRST_N,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [3:0]       PSTRB,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] GpioIn,
  output logic [WIDTH-1:0] GpioOut,
  output logic [WIDTH-1:0] GpioOEn,
  output logic             GpioIrq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_DIV < 2) begin : g_param_check
    $error("apb_gpio_irq: parameter out of range");
  end

  localparam logic [5:0] A_IN    = 6'd0;
  localparam logic [5:0] A_OUT   = 6'd1;
  localparam logic [5:0] A_DIR   = 6'd2;
  localparam logic [5:0] A_SET   = 6'd3;
  localparam logic [5:0] A_CLR   = 6'd4;
  localparam logic [5:0] A_TGL   = 6'd5;
  localparam logic [5:0] A_IE    = 6'd6;
  localparam logic [5:0] A_ITYPE = 6'd7;
  localparam logic [5:0] A_IPOL  = 6'd8;
  localparam logic [5:0] A_ISTAT = 6'd9;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [5:0]       addr_idx;
  logic             mapped;
  logic             wr_en;
  logic [31:0]      byte_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;

  assign addr_idx  = PADDR[7:2];
  assign mapped    = (addr_idx <= A_ISTAT);
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign byte_mask = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign wmask     = byte_mask[WIDTH-1:0];
  // Data bits that are both written and strobed. SET/CLR/TGL and the ISTAT
  // clear act only on these bits.
  assign wbits     = PWDATA[WIDTH-1:0] & wmask;

  // PADDR[1:0] and data bits above WIDTH are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA, byte_mask};

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] in_v;

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= GpioIn;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  // A free-running prescaler produces one tick every DEB_DIV cycles. Each pin
  // keeps its last two tick samples. IN follows s_in only when the current
  // sample and both history samples agree.
  localparam int PW = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] hist0;
  logic [WIDTH-1:0] hist1;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] stable;

  assign tick   = (pre_cnt == PW'(DEB_DIV - 1));
  assign stable = ~(s_in ^ hist0) & ~(hist0 ^ hist1);

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      pre_cnt <= '0;
      hist0   <= '0;
      hist1   <= '0;
      deb_q   <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        hist1   <= hist0;
        hist0   <= s_in;
        deb_q   <= (deb_q & ~stable) | (s_in & stable);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  assign in_v = deb_q;
`else
  assign in_v = s_in;
`endif

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] itype_q;
  logic [WIDTH-1:0] ipol_q;

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      out_q   <= '0;
      dir_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
    end else if (wr_en) begin
      case (addr_idx)
        A_OUT:   out_q   <= (out_q & ~wmask) | wbits;
        A_SET:   out_q   <= out_q | wbits;
        A_CLR:   out_q   <= out_q & ~wbits;
        A_TGL:   out_q   <= out_q ^ wbits;
        A_DIR:   dir_q   <= (dir_q & ~wmask) | wbits;
        A_IE:    ie_q    <= (ie_q & ~wmask) | wbits;
        A_ITYPE: itype_q <= (itype_q & ~wmask) | wbits;
        A_IPOL:  ipol_q  <= (ipol_q & ~wmask) | wbits;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt detection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] istat_q;
  logic [WIDTH-1:0] istat_nxt;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] w1c;
  logic             irq_q;

  assign edge_ev = (in_v & ~prev_in & ipol_q) | (~in_v & prev_in & ~ipol_q);
  assign w1c     = (wr_en && addr_idx == A_ISTAT) ? wbits : '0;

  // Edge bits are sticky. The event is OR'd in after the clear, so an event on
  // the same edge as a W1C wins. Level bits ignore W1C and track the pin.
  assign istat_nxt = (itype_q & ((istat_q & ~w1c) | edge_ev))
                   | (~itype_q & ~(in_v ^ ipol_q));

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      prev_in <= '0;
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_in <= in_v;
      istat_q <= istat_nxt;
      irq_q   <= |(istat_q & ie_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and APB response
  // ---------------------------------------------------------------------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (addr_idx)
      A_IN:    rd_val[WIDTH-1:0] = in_v;
      A_OUT:   rd_val[WIDTH-1:0] = out_q;
      A_DIR:   rd_val[WIDTH-1:0] = dir_q;
      A_IE:    rd_val[WIDTH-1:0] = ie_q;
      A_ITYPE: rd_val[WIDTH-1:0] = itype_q;
      A_IPOL:  rd_val[WIDTH-1:0] = ipol_q;
      A_ISTAT: rd_val[WIDTH-1:0] = istat_q;
      default: ;
    endcase
  end

  // The response is gated by PRST_N so that a reset in the middle of a
  // transfer drops PREADY at once, without waiting for the master.
  assign PREADY  = PRST_N & PSEL & PENABLE;
  assign PSLVERR = PREADY & ~mapped;
  assign PRDATA  = (PRST_N && PSEL && !PWRITE) ? rd_val : 32'h0;

  assign GpioOut = out_q;
  assign GpioOEn = dir_q;
  assign GpioIrq = irq_q;

endmodule
